player_motion: RTL and testbench



---
 rtl/bm_pkg.sv | 40 ++++
 rtl/player_motion.sv | 147 ++++++++++++++
 tb/tb_player_motion.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bm_pkg.sv
// Definitions shared by the player, map ROM and bomb logic: arena geometry,
// movement directions and the HID keycodes that drive them.
package bm_pkg;

    localparam int unsigned TILE       = 32;
    localparam int unsigned ARENA_COLS = 20;
    localparam int unsigned ARENA_ROWS = 15;

    localparam logic [7:0] KEY_W = 8'h1A;
    localparam logic [7:0] KEY_A = 8'h04;
    localparam logic [7:0] KEY_S = 8'h16;
    localparam logic [7:0] KEY_D = 8'h07;

    typedef enum logic [1:0] {
        UP    = 2'd0,
        LEFT  = 2'd1,
        DOWN  = 2'd2,
        RIGHT = 2'd3
    } dir_t;

    typedef struct packed {
        logic valid;
        dir_t dir;
    } key_req_t;

    function automatic key_req_t decode_key(input logic [7:0] code);
        key_req_t req;
        req.valid = 1'b1;
        req.dir   = UP;
        case (code)
            KEY_W:   req.dir = UP;
            KEY_A:   req.dir = LEFT;
            KEY_S:   req.dir = DOWN;
            KEY_D:   req.dir = RIGHT;
            default: req.valid = 1'b0;
        endcase
        return req;
    endfunction

endpackage

// File: rtl/player_motion.sv
// Tile-to-tile player movement: decodes W/A/S/D, checks the wall map for the
// target tile, then slides the sprite STEP pixels per frame until it lands.
module player_motion #(
    parameter int unsigned TILE        = bm_pkg::TILE,
    parameter int unsigned STEP        = 2,
    parameter int unsigned X_OFS       = 29,
    parameter int unsigned Y_OFS       = 29,
    parameter int unsigned COL_MIN     = 1,
    parameter int unsigned COL_MAX     = 18,
    parameter int unsigned ROW_MIN     = 1,
    parameter int unsigned ROW_MAX     = 13,
    parameter int unsigned START_COL   = 1,
    parameter int unsigned START_ROW   = 1,
    parameter int unsigned SPRITE_SIZE = 26
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_clk,
    input  logic [7:0] keycode,
    input  logic       tile_blocked,
    output logic [4:0] query_col,
    output logic [3:0] query_row,
    output logic [9:0] WplayerX,
    output logic [9:0] WplayerY,
    output logic [9:0] Wplayer_size,
    output logic [1:0] facing,
    output logic       moving
);
    import bm_pkg::*;

    typedef enum logic [1:0] {S_IDLE, S_QUERY, S_DECIDE, S_MOVE} state_t;

    state_t     r_state, w_state_nx;
    logic [4:0] r_col, w_col_nx, r_qcol, w_qcol_nx;
    logic [3:0] r_row, w_row_nx, r_qrow, w_qrow_nx;
    logic [9:0] r_x, w_x_nx, r_y, w_y_nx;
    dir_t       r_facing, w_facing_nx;
    logic       r_moving, w_moving_nx;
    logic       r_fclk_q;

    logic       w_tick;
    key_req_t   w_key;
    int         w_tc, w_tr;
    logic [9:0] w_tgt_x, w_tgt_y;

    assign w_tick  = frame_clk & ~r_fclk_q;
    assign w_key   = decode_key(keycode);
    // The query address doubles as the move target until the next query.
    assign w_tgt_x = 10'(int'(r_qcol) * int'(TILE) + int'(X_OFS));
    assign w_tgt_y = 10'(int'(r_qrow) * int'(TILE) + int'(Y_OFS));

    always_comb begin
        w_tc = int'(r_col);
        w_tr = int'(r_row);
        case (w_key.dir)
            UP:      w_tr = int'(r_row) - 1;
            LEFT:    w_tc = int'(r_col) - 1;
            DOWN:    w_tr = int'(r_row) + 1;
            default: w_tc = int'(r_col) + 1;
        endcase
    end

    always_comb begin
        w_state_nx  = r_state;
        w_col_nx    = r_col;
        w_row_nx    = r_row;
        w_qcol_nx   = r_qcol;
        w_qrow_nx   = r_qrow;
        w_x_nx      = r_x;
        w_y_nx      = r_y;
        w_facing_nx = r_facing;
        w_moving_nx = r_moving;
        case (r_state)
            S_IDLE: begin
                if (w_tick && w_key.valid) begin
                    w_facing_nx = w_key.dir;
                    if (w_tc >= int'(COL_MIN) && w_tc <= int'(COL_MAX) &&
                        w_tr >= int'(ROW_MIN) && w_tr <= int'(ROW_MAX)) begin
                        w_qcol_nx  = 5'(w_tc);
                        w_qrow_nx  = 4'(w_tr);
                        w_state_nx = S_QUERY;
                    end
                end
            end
            S_QUERY: w_state_nx = S_DECIDE;
            S_DECIDE: begin
                if (tile_blocked) begin
                    w_state_nx = S_IDLE;
                end else begin
                    w_state_nx  = S_MOVE;
                    w_moving_nx = 1'b1;
                end
            end
            default: begin
                if (w_tick) begin
                    case (r_facing)
                        UP:      w_y_nx = r_y - 10'(STEP);
                        LEFT:    w_x_nx = r_x - 10'(STEP);
                        DOWN:    w_y_nx = r_y + 10'(STEP);
                        default: w_x_nx = r_x + 10'(STEP);
                    endcase
                    if (w_x_nx == w_tgt_x && w_y_nx == w_tgt_y) begin
                        w_col_nx    = r_qcol;
                        w_row_nx    = r_qrow;
                        w_moving_nx = 1'b0;
                        w_state_nx  = S_IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_state  <= S_IDLE;
            r_col    <= 5'(START_COL);
            r_row    <= 4'(START_ROW);
            r_qcol   <= '0;
            r_qrow   <= '0;
            r_x      <= 10'(START_COL * TILE + X_OFS);
            r_y      <= 10'(START_ROW * TILE + Y_OFS);
            r_facing <= DOWN;
            r_moving <= 1'b0;
            r_fclk_q <= 1'b1;
        end else begin
            r_state  <= w_state_nx;
            r_col    <= w_col_nx;
            r_row    <= w_row_nx;
            r_qcol   <= w_qcol_nx;
            r_qrow   <= w_qrow_nx;
            r_x      <= w_x_nx;
            r_y      <= w_y_nx;
            r_facing <= w_facing_nx;
            r_moving <= w_moving_nx;
            r_fclk_q <= frame_clk;
        end
    end

    assign query_col    = r_qcol;
    assign query_row    = r_qrow;
    assign WplayerX     = r_x;
    assign WplayerY     = r_y;
    assign Wplayer_size = 10'(SPRITE_SIZE);
    assign facing       = r_facing;
    assign moving       = r_moving;

endmodule

// File: tb/tb_player_motion.sv
// Bench for player_motion: frame-level reference model of the player's tile
// position, move progress and facing, with a registered wall-map ROM.
module tb_player_motion;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       frame_clk = 1'b1;
    logic [7:0] keycode = 8'h00;
    logic       tile_blocked = 1'b0;
    logic [4:0] query_col;
    logic [3:0] query_row;
    logic [9:0] WplayerX, WplayerY, Wplayer_size;
    logic [1:0] facing;
    logic       moving;

    player_motion dut (
        .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .keycode(keycode),
        .tile_blocked(tile_blocked), .query_col(query_col), .query_row(query_row),
        .WplayerX(WplayerX), .WplayerY(WplayerY), .Wplayer_size(Wplayer_size),
        .facing(facing), .moving(moving)
    );

    always #5 Clk = ~Clk;

    logic map_blk [0:31][0:15];
    always @(posedge Clk) tile_blocked <= map_blk[query_col][query_row];

    int n_vec = 0;
    int n_err = 0;

    // Reference model: tile position plus ticks elapsed in the current move.
    int         m_col, m_row, m_prog;
    logic [1:0] m_face;
    logic       m_moving;
    logic [4:0] m_qcol;
    logic [3:0] m_qrow;

    function automatic int ddx(input logic [1:0] f);
        return (f == 2'd3) ? 1 : (f == 2'd1) ? -1 : 0;
    endfunction

    function automatic int ddy(input logic [1:0] f);
        return (f == 2'd2) ? 1 : (f == 2'd0) ? -1 : 0;
    endfunction

    function automatic logic [9:0] exp_x();
        return 10'(m_col * 32 + 29 + (m_moving ? ddx(m_face) * m_prog * 2 : 0));
    endfunction

    function automatic logic [9:0] exp_y();
        return 10'(m_row * 32 + 29 + (m_moving ? ddy(m_face) * m_prog * 2 : 0));
    endfunction

    task automatic model_reset();
        m_col = 1; m_row = 1; m_prog = 0;
        m_face = 2'd2; m_moving = 1'b0; m_qcol = '0; m_qrow = '0;
    endtask

    task automatic model_tick(input logic [7:0] key);
        int d, tc, tr;
        bit v;
        if (m_moving) begin
            m_prog++;
            if (m_prog == 16) begin
                m_col += ddx(m_face);
                m_row += ddy(m_face);
                m_moving = 1'b0;
                m_prog = 0;
            end
        end else begin
            v = 1'b1;
            d = 0;
            case (key)
                8'h1A: d = 0;
                8'h04: d = 1;
                8'h16: d = 2;
                8'h07: d = 3;
                default: v = 1'b0;
            endcase
            if (v) begin
                m_face = 2'(d);
                tc = m_col + ddx(m_face);
                tr = m_row + ddy(m_face);
                if (tc >= 1 && tc <= 18 && tr >= 1 && tr <= 13) begin
                    m_qcol = 5'(tc);
                    m_qrow = 4'(tr);
                    if (!map_blk[tc][tr]) begin
                        m_moving = 1'b1;
                        m_prog = 0;
                    end
                end
            end
        end
    endtask

    // One frame: rising frame_clk with the given key, 9 Clk cycles total.
    task automatic do_frame(input logic [7:0] key);
        @(negedge Clk);
        keycode = key;
        frame_clk = 1'b1;
        model_tick(key);
        repeat (3) @(negedge Clk);
        frame_clk = 1'b0;
        repeat (5) @(negedge Clk);
    endtask

    task automatic reset_dut();
        @(negedge Clk);
        Reset_n = 1'b0;
        frame_clk = 1'b0;
        keycode = 8'h00;
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        model_reset();
        repeat (2) @(negedge Clk);
    endtask

    task automatic clear_map();
        for (int c = 0; c < 32; c++)
            for (int r = 0; r < 16; r++)
                map_blk[c][r] = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge Clk);
        Reset_n = 1'b0;
        frame_clk = 1'b1;
        keycode = 8'h07;
        repeat (3) @(negedge Clk);
        Reset_n = 1'b1;
        model_reset();
        repeat (3) @(negedge Clk);
        n_vec++;
        if ({WplayerX, WplayerY, facing, moving, query_col, query_row, Wplayer_size} !==
            {10'd61, 10'd61, 2'd2, 1'b0, 5'd0, 4'd0, 10'd26}) begin
            n_err++;
            $display("FAIL reset: got X=%0d Y=%0d face=%0d mv=%0d q=(%0d,%0d) size=%0d, want 61 61 2 0 (0,0) 26",
                     WplayerX, WplayerY, facing, moving, query_col, query_row, Wplayer_size);
        end
        frame_clk = 1'b0;
        keycode = 8'h00;
        repeat (2) @(negedge Clk);
    endtask

    task automatic test_open_move();
        clear_map();
        reset_dut();
        for (int t = 1; t <= 16; t++) begin
            do_frame(8'h07);
            n_vec++;
            if ({WplayerX, WplayerY, facing, moving, query_col, query_row} !==
                {exp_x(), exp_y(), m_face, m_moving, m_qcol, m_qrow}) begin
                n_err++;
                $display("FAIL open_move frame %0d: got X=%0d Y=%0d f=%0d mv=%0d q=(%0d,%0d) want X=%0d Y=%0d f=%0d mv=%0d q=(%0d,%0d)",
                         t, WplayerX, WplayerY, facing, moving, query_col, query_row,
                         exp_x(), exp_y(), m_face, m_moving, m_qcol, m_qrow);
            end
        end
        // Frame 1 only starts the move, so pixel ticks lag frames by one.
        do_frame(8'h00);
        n_vec++;
        if ({WplayerX, moving} !== {10'd93, 1'b0}) begin
            n_err++;
            $display("FAIL open_move end: got X=%0d mv=%0d, want X=93 mv=0", WplayerX, moving);
        end
    endtask

    task automatic test_first_tick_step();
        clear_map();
        reset_dut();
        do_frame(8'h07);
        do_frame(8'h07);
        n_vec++;
        if ({WplayerX, moving} !== {10'd63, 1'b1}) begin
            n_err++;
            $display("FAIL first_step: got X=%0d mv=%0d, want X=63 mv=1", WplayerX, moving);
        end
    endtask

    task automatic test_blocked();
        clear_map();
        map_blk[1][2] = 1'b1;
        reset_dut();
        do_frame(8'h16);
        n_vec++;
        if ({WplayerX, WplayerY, facing, moving, query_col, query_row} !==
            {10'd61, 10'd61, 2'd2, 1'b0, 5'd1, 4'd2}) begin
            n_err++;
            $display("FAIL blocked: got X=%0d Y=%0d f=%0d mv=%0d q=(%0d,%0d), want 61 61 2 0 (1,2)",
                     WplayerX, WplayerY, facing, moving, query_col, query_row);
        end
        // The FSM must be back in IDLE: the very next frame starts a move.
        do_frame(8'h07);
        n_vec++;
        if ({moving, facing, query_col, query_row} !== {m_moving, m_face, m_qcol, m_qrow}) begin
            n_err++;
            $display("FAIL blocked_recover: got mv=%0d f=%0d q=(%0d,%0d), want mv=%0d f=%0d q=(%0d,%0d)",
                     moving, facing, query_col, query_row, m_moving, m_face, m_qcol, m_qrow);
        end
    endtask

    task automatic test_boundary();
        clear_map();
        reset_dut();
        do_frame(8'h04);
        n_vec++;
        if ({WplayerX, facing, moving, query_col, query_row} !== {10'd61, 2'd1, 1'b0, 5'd0, 4'd0}) begin
            n_err++;
            $display("FAIL boundary_left: got X=%0d f=%0d mv=%0d q=(%0d,%0d), want 61 1 0 (0,0)",
                     WplayerX, facing, moving, query_col, query_row);
        end
        do_frame(8'h1A);
        n_vec++;
        if ({WplayerY, facing, moving, query_col, query_row} !== {10'd61, 2'd0, 1'b0, 5'd0, 4'd0}) begin
            n_err++;
            $display("FAIL boundary_up: got Y=%0d f=%0d mv=%0d q=(%0d,%0d), want 61 0 0 (0,0)",
                     WplayerY, facing, moving, query_col, query_row);
        end
    endtask

    task automatic test_release_mid_move();
        clear_map();
        reset_dut();
        for (int t = 0; t < 6; t++) do_frame(8'h07);
        for (int t = 0; t < 11; t++) do_frame(8'h00);
        n_vec++;
        if ({WplayerX, moving} !== {10'd93, 1'b0}) begin
            n_err++;
            $display("FAIL release_end: got X=%0d mv=%0d, want X=93 mv=0", WplayerX, moving);
        end
        do_frame(8'h00);
        do_frame(8'h00);
        n_vec++;
        if ({WplayerX, WplayerY, moving} !== {10'd93, 10'd61, 1'b0}) begin
            n_err++;
            $display("FAIL release_idle: got X=%0d Y=%0d mv=%0d, want 93 61 0", WplayerX, WplayerY, moving);
        end
    endtask

    task automatic test_reset_mid_move();
        clear_map();
        reset_dut();
        for (int t = 0; t < 9; t++) do_frame(8'h07);
        n_vec++;
        if ({WplayerX, moving} !== {10'd77, 1'b1}) begin
            n_err++;
            $display("FAIL pre_reset: got X=%0d mv=%0d, want X=77 mv=1", WplayerX, moving);
        end
        @(negedge Clk);
        Reset_n = 1'b0;
        @(negedge Clk);
        model_reset();
        n_vec++;
        if ({WplayerX, WplayerY, facing, moving, query_col, query_row} !==
            {10'd61, 10'd61, 2'd2, 1'b0, 5'd0, 4'd0}) begin
            n_err++;
            $display("FAIL reset_mid_move: got X=%0d Y=%0d f=%0d mv=%0d q=(%0d,%0d), want 61 61 2 0 (0,0)",
                     WplayerX, WplayerY, facing, moving, query_col, query_row);
        end
        Reset_n = 1'b1;
        do_frame(8'h00);
        do_frame(8'h00);
        n_vec++;
        if ({WplayerX, moving} !== {10'd61, 1'b0}) begin
            n_err++;
            $display("FAIL post_reset_idle: got X=%0d mv=%0d, want X=61 mv=0", WplayerX, moving);
        end
    endtask

    task automatic test_random();
        logic [7:0] keys [0:5];
        logic [7:0] k;
        keys[0] = 8'h1A; keys[1] = 8'h04; keys[2] = 8'h16;
        keys[3] = 8'h07; keys[4] = 8'h00; keys[5] = 8'h55;
        clear_map();
        for (int c = 0; c < 20; c++)
            for (int r = 0; r < 15; r++)
                map_blk[c][r] = ($urandom_range(0, 3) == 0);
        map_blk[1][1] = 1'b0;
        reset_dut();
        for (int f = 0; f < 400; f++) begin
            k = keys[$urandom_range(0, 5)];
            do_frame(k);
            n_vec++;
            if ({WplayerX, WplayerY, facing, moving, query_col, query_row} !==
                {exp_x(), exp_y(), m_face, m_moving, m_qcol, m_qrow}) begin
                n_err++;
                $display("FAIL random frame %0d key=%02h: got X=%0d Y=%0d f=%0d mv=%0d q=(%0d,%0d) want X=%0d Y=%0d f=%0d mv=%0d q=(%0d,%0d)",
                         f, k, WplayerX, WplayerY, facing, moving, query_col, query_row,
                         exp_x(), exp_y(), m_face, m_moving, m_qcol, m_qrow);
            end
        end
    endtask

    initial begin
        clear_map();
        model_reset();
        test_reset();
        test_first_tick_step();
        test_open_move();
        test_blocked();
        test_boundary();
        test_release_mid_move();
        test_reset_mid_move();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
